// File: rtl/data_mem_ctrl.sv
// Data-memory initiator: sequences addr/wdata/we/oe timing for core load/store requests.
// Optional write-verify readback is enabled with `define DATA_MEM_CTRL_WRITE_VERIFY_EN.
module data_mem_ctrl #(
  parameter int D_ADDR_W     = 12,
  parameter int DATA_W       = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1,
  parameter int READ_CYCLES  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [D_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [D_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic                mem_oe,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_HR = (HOLD_CYCLES > READ_CYCLES) ? HOLD_CYCLES : READ_CYCLES;
  localparam int MAX_P  = (MAX_SP > MAX_HR) ? MAX_SP : MAX_HR;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] READ_LD  = CW'(READ_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
`ifdef DATA_MEM_CTRL_WRITE_VERIFY_EN
    V_READ,
`endif
    R_READ,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [D_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                oe_q, oe_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
`ifdef DATA_MEM_CTRL_WRITE_VERIFY_EN
  logic                err_q, err_d;
`endif

  // The counter is loaded with (cycles-1) on entry; a state exits on the edge where it reads 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    oe_d        = oe_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
`ifdef DATA_MEM_CTRL_WRITE_VERIFY_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          ready_d = 1'b0;
          if (req_write) begin
            state_d = W_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = R_READ;
            cnt_d   = READ_LD;
            oe_d    = 1'b1;
          end
        end
      end
      W_SETUP: begin
        if (cnt_q == '0) begin
          state_d = W_PULSE;
          cnt_d   = PULSE_LD;
          we_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      W_PULSE: begin
        if (cnt_q == '0) begin
          state_d = W_HOLD;
          cnt_d   = HOLD_LD;
          we_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      W_HOLD: begin
        if (cnt_q == '0) begin
`ifdef DATA_MEM_CTRL_WRITE_VERIFY_EN
          state_d = V_READ;
          cnt_d   = READ_LD;
          oe_d    = 1'b1;
`else
          state_d     = DONE;
          rsp_valid_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef DATA_MEM_CTRL_WRITE_VERIFY_EN
      V_READ: begin
        if (cnt_q == '0) begin
          state_d     = DONE;
          oe_d        = 1'b0;
          rdata_d     = mem_rdata;
          err_d       = (mem_rdata != wdata_q);
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      R_READ: begin
        if (cnt_q == '0) begin
          state_d     = DONE;
          oe_d        = 1'b0;
          rdata_d     = mem_rdata;
`ifdef DATA_MEM_CTRL_WRITE_VERIFY_EN
          err_d       = 1'b0;
`endif
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
        oe_d    = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
`ifdef DATA_MEM_CTRL_WRITE_VERIFY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
`ifdef DATA_MEM_CTRL_WRITE_VERIFY_EN
      err_q       <= err_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_oe    = oe_q;
`ifdef DATA_MEM_CTRL_WRITE_VERIFY_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: vector table of loads/stores plus hand-written
// sequences for async reset, busy-time request holding and write-verify.
module tb_data_mem_ctrl;

`ifdef DATA_MEM_CTRL_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
  localparam int ST_LAT = 5;
`else
  localparam bit VERIFY = 1'b0;
  localparam int ST_LAT = 3;
`endif
  localparam int LD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_oe;
  logic [7:0]  rd_mask;
  logic [7:0]  mem [0:4095];

  int tests = 0;
  int fails = 0;

  data_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: level-sensitive write seen at each edge while we is high.
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_oe ? (mem[mem_addr] ^ rd_mask) : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic wr, input logic [11:0] a, input logic [7:0] d,
                         output int lat, output int we_n, output int oe_n,
                         output int bad_addr, output int both,
                         output logic [7:0] rd, output logic er);
    lat = -1; we_n = 0; oe_n = 0; bad_addr = 0; both = 0;
    @(negedge clk);
    check("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(posedge clk);
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = 1'b0; req_addr = ~a; req_wdata = ~d;
      end
      if (rsp_valid) begin
        lat = k;
      end else begin
        if (mem_we) we_n++;
        if (mem_oe) oe_n++;
        if (mem_we && mem_oe) both++;
        if (mem_addr !== a || (wr && mem_wdata !== d)) bad_addr++;
      end
    end
    rd = rsp_rdata;
    er = rsp_err;
    if (lat < 0) check("rsp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("rsp_single_pulse", {31'b0, rsp_valid}, 32'd0);
    check("ready_after_done", {31'b0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [11];
  logic [7:0] last_rd;

  initial begin
    int lat, we_n, oe_n, bad, both, flag;
    logic [7:0] rd;
    logic er;

    vecs[0]  = '{1'b1, 12'h123, 8'hA5, 8'h00};
    vecs[1]  = '{1'b0, 12'h123, 8'h00, 8'hA5};
    vecs[2]  = '{1'b1, 12'h045, 8'h5A, 8'h00};
    vecs[3]  = '{1'b0, 12'h045, 8'h00, 8'h5A};
    vecs[4]  = '{1'b0, 12'h123, 8'h00, 8'hA5};
    vecs[5]  = '{1'b1, 12'hFFF, 8'hFF, 8'h00};
    vecs[6]  = '{1'b1, 12'h000, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 12'hFFF, 8'h00, 8'hFF};
    vecs[8]  = '{1'b0, 12'h000, 8'h00, 8'h00};
    vecs[9]  = '{1'b1, 12'h7FE, 8'h81, 8'h00};
    vecs[10] = '{1'b0, 12'h7FE, 8'h00, 8'h81};

    rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rd_mask = '0;

    // Async reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_outputs", {19'b0, rsp_valid, rsp_err, mem_we, mem_oe, 8'b0},
          32'd0);
    check("rst_mem_addr", {20'b0, mem_addr}, 32'd0);
    check("rst_rdata", {24'b0, rsp_rdata}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd = 8'h00;

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, we_n, oe_n, bad, both, rd, er);
      if (vecs[i].wr) last_rd = VERIFY ? vecs[i].wdata : last_rd;
      else            last_rd = vecs[i].exp_rd;
      $display("[TB] txn %0d %s addr=%03h wdata=%02h lat=%0d rdata=%02h err=%0b",
               i, vecs[i].wr ? "ST" : "LD", vecs[i].addr, vecs[i].wdata, lat, rd, er);
      check("latency", lat, vecs[i].wr ? ST_LAT : LD_LAT);
      check("rsp_rdata", {24'b0, rd}, {24'b0, last_rd});
      check("rsp_err", {31'b0, er}, 32'd0);
      check("we_cycles", we_n, vecs[i].wr ? 1 : 0);
      check("oe_cycles", oe_n, (!vecs[i].wr || VERIFY) ? 2 : 0);
      check("addr_stable", bad, 0);
      check("we_oe_overlap", both, 0);
    end
    check("mem_model_123", {24'b0, mem[12'h123]}, 32'hA5);

    // Held request while busy: the second request (load 0x045) must wait for IDLE.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h123; req_wdata = 8'h11;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b0; req_addr = 12'h045;
    flag = 0;
    for (int k = 0; k < ST_LAT; k++) begin
      if (k > 0) @(negedge clk);
      if (req_ready || rsp_valid || mem_addr !== 12'h123) flag++;
    end
    @(negedge clk);
    check("hold_rsp_pulse", {30'b0, rsp_valid, req_ready}, 32'h2);
    @(negedge clk);
    check("hold_ready_gap", {30'b0, rsp_valid, req_ready}, 32'h1);
    check("hold_busy_clean", flag, 0);
    @(negedge clk);
    check("hold_accept_045", {19'b0, req_ready, mem_oe, mem_addr}, {19'b0, 1'b0, 1'b1, 12'h045});
    req_valid = 1'b0;
    lat = -1;
    for (int k = 1; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (rsp_valid) lat = k;
    end
    $display("[TB] held-request load 045 lat=%0d rdata=%02h", lat, rsp_rdata);
    check("hold_load_lat", lat, LD_LAT);
    check("hold_load_rdata", {24'b0, rsp_rdata}, 32'h5A);
    check("hold_store_mem", {24'b0, mem[12'h123]}, 32'h11);

    // Async reset during W_PULSE.
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h300; req_wdata = 8'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pulse_we_high", {31'b0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_we_low", {31'b0, mem_we}, 32'd0);
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    check("abort_outputs", {29'b0, rsp_valid, mem_oe, rsp_err}, 32'd0);
    flag = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid || mem_we) flag++;
    end
    rst_n = 1'b1;
    last_rd = 8'h00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid || mem_we || !req_ready) flag++;
    end
    $display("[TB] aborted store 300, post-reset ready=%0b", req_ready);
    check("abort_no_rsp", flag, 0);

    // Write-verify behaviour with a faulty and a good readback.
    rd_mask = 8'h01;
    run_txn(1'b1, 12'h200, 8'h3C, lat, we_n, oe_n, bad, both, rd, er);
    rd_mask = 8'h00;
    $display("[TB] verify-bad store 200 lat=%0d rdata=%02h err=%0b", lat, rd, er);
    check("vfy_bad_lat", lat, ST_LAT);
    check("vfy_bad_err", {31'b0, er}, VERIFY ? 32'd1 : 32'd0);
    check("vfy_bad_rdata", {24'b0, rd}, VERIFY ? 32'h3D : {24'b0, last_rd});
    if (VERIFY) last_rd = 8'h3C;
    run_txn(1'b1, 12'h201, 8'h3C, lat, we_n, oe_n, bad, both, rd, er);
    $display("[TB] verify-good store 201 lat=%0d rdata=%02h err=%0b", lat, rd, er);
    check("vfy_good_err", {31'b0, er}, 32'd0);
    check("vfy_good_rdata", {24'b0, rd}, {24'b0, last_rd});
    run_txn(1'b0, 12'h200, 8'h00, lat, we_n, oe_n, bad, both, rd, er);
    $display("[TB] load 200 lat=%0d rdata=%02h err=%0b", lat, rd, er);
    check("vfy_load_rdata", {24'b0, rd}, 32'h3C);
    check("vfy_load_err", {31'b0, er}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
